// File: rtl/hd_cpu_pkg.sv
// Shared encodings for the HD-CPU hardwired controller: sequencer states and console mode codes.
package hd_cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } hd_state_t;

    // Console SW codes as seen by the decode logic through MODE.
    localparam logic [2:0] MODE_RUN    = 3'b000;
    localparam logic [2:0] MODE_RD_MEM = 3'b010;
    localparam logic [2:0] MODE_WR_MEM = 3'b001;
    localparam logic [2:0] MODE_RD_REG = 3'b011;
    localparam logic [2:0] MODE_WR_REG = 3'b100;

endpackage

// File: rtl/hd_beat_shift.sv
// One-hot beat shifter: clear wins over load_w1, which wins over advance.
module hd_beat_shift #(
    parameter int NBEATS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_w1,
    input  logic              clear,
    input  logic              advance,
    output logic [NBEATS-1:0] w
);

    localparam logic [NBEATS-1:0] W1 = {{(NBEATS-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w <= '0;
        end else if (clear) begin
            w <= '0;
        end else if (load_w1) begin
            w <= W1;
        end else if (advance) begin
            w <= {w[NBEATS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hd_beat_sequencer.sv
// Beat generator and run/halt sequencer for the HD-CPU controller.
// Optional HD_SINGLE_STEP_EN adds a STEP input that halts after every cycle like STOP.
module hd_beat_sequencer
    import hd_cpu_pkg::*;
#(
    parameter int NBEATS   = 3,
    parameter int DEFBEATS = 2,
    parameter int CNT_W    = 4
) (
    input  logic              T3,
    input  logic              CLR,
    input  logic [2:0]        SW,
    input  logic              START,
    input  logic              SHORT,
    input  logic              LONG,
    input  logic              STOP,
    input  logic              SET_ST0,
`ifdef HD_SINGLE_STEP_EN
    input  logic              STEP,
`endif
    output logic [NBEATS-1:0] W,
    output logic              ST0,
    output logic [2:0]        MODE,
    output logic              RUNNING,
    output logic              CYC_DONE,
    output logic [CNT_W-1:0]  COUNT,
    output hd_state_t         state_dbg
);

    hd_state_t state, state_nx;

    logic long_q;
    logic long_here;
    logic last_beat;
    logic halt_req;
    logic load_w1;
    logic clear_w;
    logic advance;
    logic cyc_end;
    logic latch_mode;

`ifdef HD_SINGLE_STEP_EN
    assign halt_req = STOP | STEP;
`else
    assign halt_req = STOP;
`endif

    // LONG only extends when there is room beyond the default length.
    assign long_here = (NBEATS > DEFBEATS) && W[DEFBEATS-1] && LONG;

    // SHORT in W1 ends the cycle regardless of LONG.
    assign last_beat = (W[0] && SHORT)
                     || (W[DEFBEATS-1] && !long_here)
                     || (W[NBEATS-1] && (long_q || (NBEATS == DEFBEATS)));

    assign RUNNING   = (state == ST_RUN);
    assign CYC_DONE  = RUNNING && last_beat;
    assign state_dbg = state;

    hd_beat_shift #(
        .NBEATS(NBEATS)
    ) u_shift (
        .clk    (T3),
        .rst    (CLR),
        .load_w1(load_w1),
        .clear  (clear_w),
        .advance(advance),
        .w      (W)
    );

    always_ff @(posedge T3 or posedge CLR) begin
        if (CLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_w1    = 1'b0;
        clear_w    = 1'b0;
        advance    = 1'b0;
        cyc_end    = 1'b0;
        latch_mode = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nx   = ST_RUN;
                    load_w1    = 1'b1;
                    latch_mode = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_beat) begin
                    cyc_end = 1'b1;
                    if (halt_req) begin
                        state_nx = ST_HALT;
                        clear_w  = 1'b1;
                    end else begin
                        load_w1 = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            ST_HALT: begin
                if (START) begin
                    state_nx = ST_RUN;
                    load_w1  = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                clear_w  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge T3 or posedge CLR) begin
        if (CLR) begin
            MODE   <= MODE_RUN;
            ST0    <= 1'b0;
            COUNT  <= '0;
            long_q <= 1'b0;
        end else begin
            if (latch_mode) begin
                MODE <= SW;
            end
            // ST0 is only ever cleared by a fresh start from IDLE.
            if (latch_mode) begin
                ST0 <= 1'b0;
            end else if (cyc_end && SET_ST0) begin
                ST0 <= 1'b1;
            end
            if (cyc_end) begin
                COUNT <= COUNT + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (cyc_end) begin
                long_q <= 1'b0;
            end else if (RUNNING && long_here) begin
                long_q <= 1'b1;
            end
        end
    end

endmodule
